pad_ownership_arbiter: RTL and testbench

- Shares one output pad cell between NREQ requesters, e.g. GPIO, a peripheral and a debug/test path.
- Arbitrates round-robin, grants exclusive ownership and inserts a turnaround window on every owner change. During that window the pad is tristated while the new owner's attributes settle.
- Sits between the requesters and the pad cell. It drives the pad cell's pad_in_i, pad_oe_i and pad_attributes_i, and forwards the cell's pad_out_o back to the current owner.

---
 rtl/pad_arb_pkg.sv | 17 +
 rtl/pad_arb_rr_pick.sv | 30 +++
 rtl/pad_ownership_arbiter.sv | 146 ++++++++++++++
 tb/tb_pad_ownership_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pad_arb_pkg.sv
// Shared types and defaults for the pad ownership arbiter.
package pad_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StTa    = 2'd1,
        StOwned = 2'd2
    } arb_state_e;

    localparam int unsigned DEFAULT_NREQ    = 4;
    localparam int unsigned DEFAULT_PADATTR = 16;

    typedef logic [$clog2(DEFAULT_NREQ)-1:0] owner_idx_t;

    localparam logic [DEFAULT_PADATTR-1:0] DEFAULT_IDLE_ATTR = '0;

endpackage

// File: rtl/pad_arb_rr_pick.sv
// Combinational round-robin pick: first asserted request after 'last', wrapping.
module pad_arb_rr_pick
    import pad_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last,
    output logic [IDXW-1:0] winner,
    output logic            valid
);

    int unsigned idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        // Offsets 1..NREQ put 'last' itself at lowest priority.
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (32'(last) + i) % NREQ;
            if (!valid && req[IDXW'(idx)]) begin
                valid  = 1'b1;
                winner = IDXW'(idx);
            end
        end
    end

endmodule

// File: rtl/pad_ownership_arbiter.sv
// Round-robin owner arbitration for one shared pad cell, with a tristated
// turnaround window before every grant and optional preemption under contention.
module pad_ownership_arbiter
    import pad_arb_pkg::*;
#(
    parameter int unsigned        NREQ       = DEFAULT_NREQ,
    parameter int unsigned        PADATTR    = DEFAULT_PADATTR,
    parameter int unsigned        TURNAROUND = 2,
    parameter int unsigned        MAX_HOLD   = 0,
    parameter logic               IDLE_VAL   = 1'b0,
    parameter logic [PADATTR-1:0] IDLE_ATTR  = DEFAULT_IDLE_ATTR
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NREQ-1:0]         req_i,
    output logic [NREQ-1:0]         gnt_o,
    input  logic [NREQ-1:0]         req_out_i,
    input  logic [NREQ-1:0]         req_oe_i,
    input  logic [NREQ*PADATTR-1:0] req_attr_i,
    output logic [NREQ-1:0]         req_rdata_o,
    output logic                    pad_in_o,
    output logic                    pad_oe_o,
    output logic [PADATTR-1:0]      pad_attributes_o,
    input  logic                    pad_out_i,
    output logic                    busy_o
);

    localparam int unsigned IdxW  = $clog2(NREQ);
    localparam int unsigned TaW   = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
    localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [TaW-1:0]   TaInit  = TaW'(TURNAROUND - 1);
    localparam logic [HoldW-1:0] HoldMax = (MAX_HOLD > 0) ? HoldW'(MAX_HOLD - 1) : '0;

    arb_state_e        state_q;
    logic [IdxW-1:0]   owner_q;
    logic [IdxW-1:0]   pend_q;
    logic [IdxW-1:0]   last_owner_q;
    logic [TaW-1:0]    ta_cnt_q;
    logic [HoldW-1:0]  hold_q;

    logic [NREQ-1:0]    owner_oh;
    logic [NREQ-1:0]    pick_req;
    logic [IdxW-1:0]    pick_idx;
    logic               pick_valid;
    logic [PADATTR-1:0] attr_arr [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_attr
        assign attr_arr[k] = req_attr_i[k*PADATTR +: PADATTR];
    end

    assign owner_oh = NREQ'(1) << owner_q;
    // While owned, last_owner_q equals owner_q; masking the owner makes the
    // same picker serve both release and preemption.
    assign pick_req = (state_q == StOwned) ? (req_i & ~owner_oh) : req_i;

    pad_arb_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IdxW)
    ) u_pick (
        .req    (pick_req),
        .last   (last_owner_q),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            gnt_o        <= '0;
            owner_q      <= '0;
            pend_q       <= '0;
            last_owner_q <= IdxW'(NREQ - 1);
            ta_cnt_q     <= '0;
            hold_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        pend_q   <= pick_idx;
                        ta_cnt_q <= TaInit;
                        state_q  <= StTa;
                    end
                end
                StTa: begin
                    if (!req_i[pend_q]) begin
                        state_q <= StIdle;
                    end else if (ta_cnt_q == '0) begin
                        state_q      <= StOwned;
                        owner_q      <= pend_q;
                        last_owner_q <= pend_q;
                        gnt_o        <= NREQ'(1) << pend_q;
                        hold_q       <= '0;
                    end else begin
                        ta_cnt_q <= ta_cnt_q - TaW'(1);
                    end
                end
                StOwned: begin
                    if (!req_i[owner_q]) begin
                        gnt_o <= '0;
                        if (pick_valid) begin
                            pend_q   <= pick_idx;
                            ta_cnt_q <= TaInit;
                            state_q  <= StTa;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if ((MAX_HOLD != 0) && (hold_q == HoldMax) && pick_valid) begin
                        gnt_o    <= '0;
                        pend_q   <= pick_idx;
                        ta_cnt_q <= TaInit;
                        state_q  <= StTa;
                    end else if (hold_q != HoldMax) begin
                        hold_q <= hold_q + HoldW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    gnt_o   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        pad_in_o         = IDLE_VAL;
        pad_oe_o         = 1'b0;
        pad_attributes_o = IDLE_ATTR;
        req_rdata_o      = '0;
        unique case (state_q)
            StTa: begin
                pad_attributes_o = attr_arr[pend_q];
            end
            StOwned: begin
                pad_in_o         = req_out_i[owner_q];
                pad_oe_o         = req_oe_i[owner_q];
                pad_attributes_o = attr_arr[owner_q];
                req_rdata_o      = pad_out_i ? owner_oh : '0;
            end
            default: begin
            end
        endcase
    end

    assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_pad_ownership_arbiter.sv
// Directed bench: stimulus pushes per-cycle expected outputs, a negedge monitor pops and compares.
module tb_pad_ownership_arbiter;
    import pad_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [3:0]  req_out;
    logic [3:0]  req_oe;
    logic [63:0] req_attr;
    logic [3:0]  rdata;
    logic        pad_in;
    logic        pad_oe;
    logic [15:0] pad_attr;
    logic        pad_out;
    logic        busy;

    always #5 clk = ~clk;

    pad_ownership_arbiter #(
        .NREQ       (4),
        .PADATTR    (16),
        .TURNAROUND (2),
        .MAX_HOLD   (8),
        .IDLE_VAL   (1'b0),
        .IDLE_ATTR  (16'h0000)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_i            (req),
        .gnt_o            (gnt),
        .req_out_i        (req_out),
        .req_oe_i         (req_oe),
        .req_attr_i       (req_attr),
        .req_rdata_o      (rdata),
        .pad_in_o         (pad_in),
        .pad_oe_o         (pad_oe),
        .pad_attributes_o (pad_attr),
        .pad_out_i        (pad_out),
        .busy_o           (busy)
    );

    typedef struct {
        string       name;
        logic [3:0]  gnt;
        logic        oe;
        logic        pin;
        logic [15:0] attr;
        logic [3:0]  rdata;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [15:0] attr_of(owner_idx_t k);
        case (k)
            2'd0:    return 16'h1111;
            2'd1:    return 16'h2222;
            2'd2:    return 16'h3333;
            default: return 16'h4444;
        endcase
    endfunction

    task automatic push(string n, logic [3:0] g, logic oe, logic pin, logic [15:0] at,
                        logic [3:0] rd, logic bz);
        exp_t e;
        e.name  = n;
        e.gnt   = g;
        e.oe    = oe;
        e.pin   = pin;
        e.attr  = at;
        e.rdata = rd;
        e.busy  = bz;
        sb.push_back(e);
    endtask

    task automatic exp_idle(string n);
        push(n, 4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0);
    endtask

    task automatic exp_ta(string n, owner_idx_t k);
        push(n, 4'b0000, 1'b0, 1'b0, attr_of(k), 4'b0000, 1'b1);
    endtask

    task automatic exp_own(string n, owner_idx_t k);
        logic [3:0] oh;
        oh = 4'b0001 << k;
        push(n, oh, req_oe[k], req_out[k], attr_of(k), pad_out ? oh : 4'b0000, 1'b1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if (gnt !== mon_e.gnt || pad_oe !== mon_e.oe || pad_in !== mon_e.pin ||
                pad_attr !== mon_e.attr || rdata !== mon_e.rdata || busy !== mon_e.busy) begin
                errors++;
                $display("FAIL %s: got gnt=%b oe=%b in=%b attr=%h rdata=%b busy=%b, want gnt=%b oe=%b in=%b attr=%h rdata=%b busy=%b",
                         mon_e.name, gnt, pad_oe, pad_in, pad_attr, rdata, busy,
                         mon_e.gnt, mon_e.oe, mon_e.pin, mon_e.attr, mon_e.rdata, mon_e.busy);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int order [5];
        owner_idx_t k;
        order    = '{0, 1, 2, 3, 0};
        rst      = 1'b1;
        req      = 4'b0000;
        req_out  = 4'b1010;
        req_oe   = 4'b0110;
        pad_out  = 1'b1;
        req_attr = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

        // Reset, then single request from requester 1.
        tick(); rst = 1'b0; req = 4'b0010; exp_idle("reset_idle");
        tick(); exp_ta("t1_ta0", 2'd1);
        tick(); exp_ta("t1_ta1", 2'd1);
        tick(); exp_own("t1_own0", 2'd1);
        tick(); req = 4'b0000; exp_own("t1_own_rel", 2'd1);
        tick(); exp_idle("t1_idle");

        // Fresh reset so requester 0 wins first, then round-robin 0,1,2,3,0.
        tick(); rst = 1'b1; exp_idle("rst2_asserted");
        tick(); rst = 1'b0; req = 4'b1111; exp_idle("rst2_idle");
        for (int r = 0; r < 5; r++) begin
            k = owner_idx_t'(order[r]);
            for (int t = 0; t < 2; t++) begin
                tick();
                if (t == 0) req = 4'b1111;
                exp_ta($sformatf("rr%0d_ta%0d", r, t), k);
            end
            for (int t = 0; t < 5; t++) begin
                tick();
                if (t == 4) req = (r == 4) ? 4'b0000 : (4'b1111 & ~(4'b0001 << k));
                exp_own($sformatf("rr%0d_own%0d", r, t), k);
            end
        end
        tick(); exp_idle("rr_idle");

        // Requester 2 alone: data/readback follow, no preemption without contention.
        tick(); req = 4'b0100; exp_idle("t3_idle");
        tick(); exp_ta("t3_ta0", 2'd2);
        tick(); exp_ta("t3_ta1", 2'd2);
        for (int i = 0; i < 12; i++) begin
            tick();
            req_out[2] = 1'(i & 1);
            pad_out    = 1'((i >> 1) & 1);
            if (i == 11) req = 4'b0000;
            exp_own($sformatf("t3_own%0d", i), 2'd2);
        end
        tick(); req_out = 4'b1010; pad_out = 1'b1; exp_idle("t3_done");

        // Preemption: 0 owns, 3 contends, 0 loses after 8 owned cycles.
        tick(); req = 4'b0001; exp_idle("t4_idle");
        tick(); exp_ta("t4_ta0", 2'd0);
        tick(); exp_ta("t4_ta1", 2'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) req = 4'b1001;
            exp_own($sformatf("t4_own0_%0d", i), 2'd0);
        end
        tick(); exp_ta("t4_pre_ta0", 2'd3);
        tick(); exp_ta("t4_pre_ta1", 2'd3);
        tick(); exp_own("t4_own3_0", 2'd3);
        tick(); exp_own("t4_own3_1", 2'd3);
        tick(); req = 4'b0001; exp_own("t4_own3_2", 2'd3);
        tick(); exp_ta("t4_back_ta0", 2'd0);
        tick(); exp_ta("t4_back_ta1", 2'd0);
        tick(); exp_own("t4_regrant0", 2'd0);
        tick(); req = 4'b0000; exp_own("t4_regrant1", 2'd0);
        tick(); exp_idle("t4_done");

        // Request withdrawn during turnaround: no grant pulse.
        tick(); req = 4'b0010; exp_idle("t5_idle");
        tick(); req = 4'b0000; exp_ta("t5_ta0", 2'd1);
        for (int i = 0; i < 3; i++) begin
            tick(); exp_idle($sformatf("t5_abort%0d", i));
        end

        // Reset pulse while owned.
        tick(); req = 4'b0001; exp_idle("t6_idle");
        tick(); exp_ta("t6_ta0", 2'd0);
        tick(); exp_ta("t6_ta1", 2'd0);
        tick(); exp_own("t6_own0", 2'd0);
        tick(); rst = 1'b1; exp_own("t6_own1", 2'd0);
        tick(); rst = 1'b0; exp_idle("t6_after_rst");
        tick(); exp_ta("t6_ta_again0", 2'd0);
        tick(); exp_ta("t6_ta_again1", 2'd0);
        tick(); req = 4'b0000; exp_own("t6_regrant", 2'd0);
        tick(); exp_idle("t6_done");

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
